relu_maxpool_2x2: RTL



---
 rtl/relu_maxpool_2x2_if.sv | 18 +
 rtl/relu_maxpool_2x2.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_2x2_if.sv
// Pixel stream bundle: one valid strobe plus one pixel word.
// The producer drives through the master modport, the consumer samples through slave.
interface relu_maxpool_2x2_if #(
  parameter int data_width = 32
);
  logic                  valid;
  logic [data_width-1:0] pxl;

  modport master (
    output valid,
    output pxl
  );

  modport slave (
    input valid,
    input pxl
  );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU followed by 2x2 / stride-2 max pooling on one raster-order
// IEEE-754 single-precision channel. Horizontal pair maxima of even rows are
// parked in a one-line buffer and combined with the odd row's pair maxima, so
// the pooled output needs no frame store. Trailing odd column/row is consumed
// and ignored. Only data_width = 32 is meaningful.
module relu_maxpool_2x2 #(
  parameter int IN_W       = 147,
  parameter int IN_H       = 147,
  parameter int data_width = 32
) (
  input  logic               clk,
  input  logic               reset,
  relu_maxpool_2x2_if.slave  in_bus,
  relu_maxpool_2x2_if.master out_bus,
  output logic               frame_done
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  // One spare bit so 2*OUT_W / 2*OUT_H always fit next to the counters.
  localparam int CW = $clog2(IN_W + 1);
  localparam int RW = $clog2(IN_H + 1);
  localparam int LW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] COL_LIM  = CW'(2 * OUT_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);
  localparam logic [RW-1:0] ROW_LIM  = RW'(2 * OUT_H);

  // Negative values (including -0 and negative NaN) collapse to +0.
  function automatic logic [31:0] relu_f(input logic [31:0] x);
    logic [31:0] r;
    if (x[31]) begin
      r = 32'h0000_0000;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Both operands are already sign-cleared, so the float order equals the
  // unsigned order of the remaining 31 bits; +Inf and positive NaN win.
  function automatic logic [31:0] max_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a[30:0] >= b[30:0]) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [31:0]   pair_r;
  logic [31:0]   pxl_out_r;
  logic          valid_out_r;
  logic          frame_done_r;
  logic [31:0]   linebuf_r [OUT_W];

  logic [31:0]   relu_s;
  logic [31:0]   h_s;
  logic [31:0]   lb_rd_s;
  logic [31:0]   win_s;
  logic [LW-1:0] lb_idx_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          pool_col_s;
  logic          pool_row_s;
  logic          accept_s;
  logic          wr_en_s;
  logic          emit_s;

  // Per-pixel datapath: ReLU, horizontal pair max, window position decode.
  always_comb begin
    relu_s     = relu_f(in_bus.pxl);
    h_s        = max_f(pair_r, relu_s);
    col_last_s = (col_r == COL_LAST);
    row_last_s = (row_r == ROW_LAST);
    pool_col_s = (col_r < COL_LIM);
    pool_row_s = (row_r < ROW_LIM);
    accept_s   = in_bus.valid & ~reset;
    wr_en_s    = accept_s & col_r[0] & pool_col_s & ~row_r[0] & pool_row_s;
    emit_s     = in_bus.valid & col_r[0] & pool_col_s & row_r[0] & pool_row_s;
  end

  // Line-buffer address; clamped to 0 outside the pooled columns so the
  // trailing odd column never forms an out-of-range index.
  always_comb begin
    lb_idx_s = {LW{1'b0}};
    if (pool_col_s) begin
      lb_idx_s = LW'(col_r >> 1);
    end else begin
      lb_idx_s = {LW{1'b0}};
    end
    lb_rd_s = linebuf_r[lb_idx_s];
    win_s   = max_f(lb_rd_s, h_s);
  end

  // Line buffer of even-row pair maxima; contents need no reset because every
  // entry is rewritten in an even row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      linebuf_r[lb_idx_s] <= h_s;
    end
  end

  // Raster counters, pair register and registered output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r        <= {CW{1'b0}};
      row_r        <= {RW{1'b0}};
      pair_r       <= 32'h0000_0000;
      pxl_out_r    <= 32'h0000_0000;
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      if (in_bus.valid) begin
        if (!col_r[0]) begin
          pair_r <= relu_s;
        end
        if (col_last_s) begin
          col_r <= {CW{1'b0}};
          if (row_last_s) begin
            row_r <= {RW{1'b0}};
          end else begin
            row_r <= row_r + RW'(1);
          end
        end else begin
          col_r <= col_r + CW'(1);
        end
        if (emit_s) begin
          valid_out_r <= 1'b1;
          pxl_out_r   <= win_s;
        end
        frame_done_r <= col_last_s & row_last_s;
      end
    end
  end

  assign out_bus.valid = valid_out_r;
  assign out_bus.pxl   = pxl_out_r;
  assign frame_done    = frame_done_r;

endmodule
